// File: rtl/iddmm_result_drain.sv
// Result collector for the IDDMM core: buffers the raw and the minus-p word streams,
// then drains the stream picked by the final sign over a valid/ready handshake.
module iddmm_result_drain #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en_a,
  input  logic [K-1:0]      i_wr_data_a,
  input  logic              i_wr_en_sub,
  input  logic [K-1:0]      i_wr_data_sub,
  input  logic              i_cal_done,
  input  logic              i_cal_sign,
  output logic              o_valid,
  output logic [K-1:0]      o_data,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_err
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(N);
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N-1);

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt_a, cnt_sub;
  logic [ADDR_W-1:0] rd_ptr;
  logic              done_pend, sel, err;
  logic [K-1:0]      buf_a   [N];
  logic [K-1:0]      buf_sub [N];

  logic full_a, full_sub, xfer;
  assign full_a   = (cnt_a == CNT_FULL);
  assign full_sub = (cnt_sub == CNT_FULL);
  assign xfer     = o_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Drain starts one cycle after everything is in, so the mux sees settled counters.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (done_pend && full_a && full_sub) state_nxt = DRAIN;
      DRAIN:   if (xfer && o_last)                  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    o_valid = (state == DRAIN);
    o_addr  = rd_ptr;
    o_last  = o_valid && (rd_ptr == LAST_PTR);
    o_data  = '0;
    if (o_valid) o_data = sel ? buf_sub[rd_ptr] : buf_a[rd_ptr];
    o_busy  = done_pend || (state == DRAIN);
    o_err   = err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a     <= '0;
      cnt_sub   <= '0;
      rd_ptr    <= '0;
      done_pend <= 1'b0;
      sel       <= 1'b0;
      err       <= 1'b0;
    end else if (state == DRAIN) begin
      if (i_wr_en_a || i_wr_en_sub || i_cal_done) err <= 1'b1;
      if (xfer) begin
        if (o_last) begin
          cnt_a     <= '0;
          cnt_sub   <= '0;
          rd_ptr    <= '0;
          done_pend <= 1'b0;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end else begin
      if (i_wr_en_a) begin
        if (full_a) err <= 1'b1;
        else        cnt_a <= cnt_a + 1'b1;
      end
      if (i_wr_en_sub) begin
        if (full_sub) err <= 1'b1;
        else          cnt_sub <= cnt_sub + 1'b1;
      end
      if (i_cal_done) begin
        if (done_pend) err <= 1'b1;
        else begin
          done_pend <= 1'b1;
          sel       <= i_cal_sign;
        end
      end
    end
  end

  // Word storage needs no reset: nothing reads it until a full load has landed.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      if (i_wr_en_a && !full_a)     buf_a[cnt_a[ADDR_W-1:0]]     <= i_wr_data_a;
      if (i_wr_en_sub && !full_sub) buf_sub[cnt_sub[ADDR_W-1:0]] <= i_wr_data_sub;
    end
  end

endmodule

// File: doc/iddmm_result_drain.md
Name: iddmm_result_drain

Overview:
- Consumer side of the IDDMM calculation core's result FIFO write interface.
- Captures both candidate result streams, emitted least-significant word first:
  - raw Montgomery result words (write port a);
  - the same words minus p (write port sub).
- Once the calculation-done pulse arrives with its sign, streams the selected N-word final result downstream over a valid/ready handshake.
- Sits between the IDDMM calculation core and the modular-exponentiation / Paillier controller.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand.
- ADDR_W, $clog2(N), word index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_wr_en_a  in  1  raw result word write strobe.
- i_wr_data_a  in  K  raw result word.
- i_wr_en_sub  in  1  subtracted result word write strobe.
- i_wr_data_sub  in  K  subtracted result word (raw - p, with borrow chain).
- i_cal_done  in  1  one-cycle pulse: calculation complete.
- i_cal_sign  in  1  valid with i_cal_done; 1 = use subtracted words, 0 = use raw words.
- o_valid  out  1  output word valid.
- o_data  out  K  output word.
- o_addr  out  ADDR_W  output word index, 0 = least significant.
- o_last  out  1  high with word N-1.
- i_ready  in  1  downstream accepts word.
- o_busy  out  1  result pending or draining; upstream must not start a new multiplication.
- o_err  out  1  sticky protocol error flag.

Behaviour:
- Reset (async) values:
  - outputs: o_valid=0, o_data=0, o_addr=0, o_last=0, o_busy=0, o_err=0.
  - internal: state=FILL, counters cnt_a=0, cnt_sub=0, rd_ptr=0, done_pend=0, sel=0.
- Storage: two K x N register arrays, buf_a and buf_sub.
- State FILL:
  - i_wr_en_a: buf_a[cnt_a] <= i_wr_data_a; cnt_a++.
  - i_wr_en_sub: buf_sub[cnt_sub] <= i_wr_data_sub; cnt_sub++.
  - Both strobes may assert in the same cycle; each is handled independently.
  - A write when its counter == N is dropped; set o_err.
  - i_cal_done: done_pend <= 1; sel <= i_cal_sign.
  - i_cal_done while done_pend is already set: ignored, sel unchanged; set o_err.
  - i_cal_done may coincide with the final i_wr_en_sub write; both are captured.
  - Transition to DRAIN on the cycle after done_pend && cnt_a==N && cnt_sub==N.
  - If done arrives before all words are in, the block waits in FILL indefinitely. There is no timeout.
- State DRAIN:
  - o_valid=1 from the first DRAIN cycle.
  - o_data = sel ? buf_sub[rd_ptr] : buf_a[rd_ptr], driven combinationally from registered state.
  - o_addr = rd_ptr; o_last = (rd_ptr == N-1).
  - Transfer on o_valid && i_ready: rd_ptr++.
  - o_data, o_addr and o_last hold stable while o_valid && !i_ready.
  - Transfer with o_last:
    - next cycle state=FILL, o_valid=0;
    - cnt_a, cnt_sub, rd_ptr, done_pend cleared.
  - Any i_wr_en_a, i_wr_en_sub or i_cal_done during DRAIN is dropped and sets o_err. Buffers and sel are unaffected.
- o_busy = done_pend || (state == DRAIN).
- o_data = 0 when o_valid = 0.
- o_err: sticky; cleared only by rst_n.
- Throughput and latency:
  - one word per cycle with i_ready held high, so N transfers in N consecutive cycles;
  - first o_valid 2 cycles after the last of {final write, i_cal_done}.
- Reset mid-operation (any state): returns to reset values immediately. Partial data is discarded and no further o_valid is asserted.

Test Plan:
- Sign 1, i_ready=1:
  - stimulus: write a-words 0x100+i and sub-words 0x200+i (i = 0..31), then i_cal_done with i_cal_sign=1;
  - required: 32 consecutive o_valid beats, o_data = 0x200+i, o_addr = i, o_last only on i=31, o_err=0.
- Sign 0: same stimulus with i_cal_sign=0 -> o_data = 0x100+i on every beat.
- Backpressure:
  - stimulus: i_ready toggles 1,0,0,1 repeating;
  - required: o_data/o_addr stable during stall cycles; exactly 32 transfers in order; state returns to FILL after the o_last transfer; o_busy falls.
- Done coincident with last write:
  - stimulus: i_cal_done together with the 32nd i_wr_en_sub;
  - required: drain starts 2 cycles later with correct sel.
  - stimulus: i_cal_done after only 20 words;
  - required: no o_valid until word 32 arrives, o_busy=1 throughout.
- Protocol errors:
  - a 33rd i_wr_en_a write -> o_err=1; stored data unchanged.
  - a write during DRAIN -> o_err=1; output sequence unchanged.
  - a second i_cal_done while pending -> o_err=1; sel unchanged.
- Reset mid-drain:
  - stimulus: assert rst_n low at beat 10;
  - required: all outputs 0 immediately; after release, a fresh 32-word load drains correctly starting from o_addr 0.
